// File: rtl/vend_if.sv
// Vending controller I/O bundle: debounced button/coin pulses and pacing tick in,
// credit/qty/state/led status and one-cycle payout pulses out.
interface vend_if #(
    parameter int CW    = 6,
    parameter int QW    = 4,
    parameter int LED_W = 16
);
    logic             money_5;
    logic             money_10;
    logic             cancel;
    logic             check;
    logic             count_down;
    logic             count_up;
    logic             tick;
    logic [CW-1:0]    credit;
    logic [QW-1:0]    qty;
    logic [2:0]       state;
    logic [LED_W-1:0] led;
    logic             coin_reject;
    logic             change_5;
    logic             change_10;
    logic             vend_done;

    modport master (
        output money_5, money_10, cancel, check, count_down, count_up, tick,
        input  credit, qty, state, led, coin_reject, change_5, change_10, vend_done
    );
    modport slave (
        input  money_5, money_10, cancel, check, count_down, count_up, tick,
        output credit, qty, state, led, coin_reject, change_5, change_10, vend_done
    );
endinterface

// File: rtl/vend_ctrl_gen.sv
// Vending machine controller: coin intake with ceiling, quantity selection with wrap,
// LED flash on release and tick-paced change payout. All outputs are registered.
module vend_ctrl_gen #(
    parameter int PRICE       = 5,
    parameter int MAX_CREDIT  = 50,
    parameter int MAX_QTY     = 9,
    parameter int TIMEOUT_CYC = 8192,
    parameter int FLASH_N     = 4,
    parameter int LED_W       = 16
) (
    input  logic   clk,
    input  logic   rst,
    vend_if.slave  bus
);
    localparam int CW = $clog2(MAX_CREDIT + 1);
    localparam int QW = $clog2(MAX_QTY + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int FW = $clog2(2 * FLASH_N + 1);
    localparam logic [CW+QW-1:0] PRICE_W = (CW+QW)'(PRICE);
    localparam logic [CW+QW-1:0] MAXQ_W  = (CW+QW)'(MAX_QTY);
    localparam logic [CW:0]      LIMIT   = (CW+1)'(MAX_CREDIT);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INSERT  = 3'd1,
        SELECT  = 3'd2,
        RELEASE = 3'd3,
        CHANGE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    credit_q, credit_d, chg_q, chg_d, cr_ins;
    logic [QW-1:0]    qty_q, qty_d, af_cur;
    logic [LED_W-1:0] led_q, led_d;
    logic [TW-1:0]    idle_q, idle_d;
    logic [FW-1:0]    flash_q, flash_d;
    logic             rej_q, rej_d, c5_q, c5_d, c10_q, c10_d, done_q, done_d;
    logic             ok5, ok10, button;
    logic [CW+QW-1:0] cost;

    function automatic logic [QW-1:0] afford_of(input logic [CW-1:0] c);
        logic [CW+QW-1:0] d;
        d = {{QW{1'b0}}, c} / PRICE_W;
        return (d > MAXQ_W) ? QW'(MAX_QTY) : d[QW-1:0];
    endfunction

    assign af_cur = afford_of(credit_q);
    assign ok10   = ({1'b0, credit_q} + (CW+1)'(10)) <= LIMIT;
    assign ok5    = ({1'b0, credit_q} + (CW+1)'(5)) <= LIMIT;
    assign cost   = {{CW{1'b0}}, qty_q} * PRICE_W;
    assign button = bus.cancel | bus.check | bus.count_up | bus.count_down;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            qty_q    <= '0;
            chg_q    <= '0;
            led_q    <= '0;
            idle_q   <= '0;
            flash_q  <= '0;
            rej_q    <= 1'b0;
            c5_q     <= 1'b0;
            c10_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            qty_q    <= qty_d;
            chg_q    <= chg_d;
            led_q    <= led_d;
            idle_q   <= idle_d;
            flash_q  <= flash_d;
            rej_q    <= rej_d;
            c5_q     <= c5_d;
            c10_q    <= c10_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        qty_d    = qty_q;
        chg_d    = chg_q;
        led_d    = led_q;
        idle_d   = idle_q;
        flash_d  = flash_q;
        rej_d    = 1'b0;
        c5_d     = 1'b0;
        c10_d    = 1'b0;
        done_d   = 1'b0;
        cr_ins   = credit_q;
        case (state_q)
            IDLE: begin
                credit_d = '0;
                qty_d    = '0;
                chg_d    = '0;
                led_d    = '0;
                idle_d   = '0;
                flash_d  = '0;
                state_d  = INSERT;
            end
            INSERT: begin
                // money_10 wins a same-cycle collision; money_5 is then bounced
                if (bus.money_10) begin
                    if (ok10) cr_ins = credit_q + CW'(10);
                    else      rej_d  = 1'b1;
                end
                if (bus.money_5) begin
                    if (!bus.money_10 && ok5) cr_ins = credit_q + CW'(5);
                    else                      rej_d  = 1'b1;
                end
                credit_d = cr_ins;
                qty_d    = af_cur;
                if (bus.cancel && cr_ins != '0) begin
                    state_d = CHANGE;
                end else if (bus.check && cr_ins != '0 && afford_of(cr_ins) != '0) begin
                    state_d = SELECT;
                    qty_d   = afford_of(cr_ins);
                    idle_d  = '0;
                end
            end
            SELECT: begin
                rej_d = bus.money_5 | bus.money_10;
                if (bus.cancel) begin
                    state_d = CHANGE;
                end else if (bus.check) begin
                    chg_d   = credit_q - cost[CW-1:0];
                    led_d   = '0;
                    flash_d = '0;
                    state_d = RELEASE;
                end else if (bus.count_up && !bus.count_down) begin
                    qty_d = (qty_q >= af_cur) ? QW'(1) : qty_q + QW'(1);
                end else if (bus.count_down && !bus.count_up) begin
                    qty_d = (qty_q <= QW'(1)) ? af_cur : qty_q - QW'(1);
                end
                if (button)                              idle_d  = '0;
                else if (idle_q == TW'(TIMEOUT_CYC - 1)) state_d = CHANGE;
                else                                     idle_d  = idle_q + TW'(1);
            end
            RELEASE: begin
                if (bus.tick) begin
                    led_d   = ~led_q;
                    flash_d = flash_q + FW'(1);
                    // last tick closes the final dark phase
                    if (flash_q == FW'(2 * FLASH_N - 1)) begin
                        led_d    = '0;
                        credit_d = chg_q;
                        done_d   = 1'b1;
                        state_d  = CHANGE;
                    end
                end
            end
            CHANGE: begin
                if (credit_q == '0) begin
                    state_d = IDLE;
                end else if (bus.tick) begin
                    if (credit_q >= CW'(10)) begin
                        credit_d = credit_q - CW'(10);
                        c10_d    = 1'b1;
                    end else if (credit_q == CW'(5)) begin
                        credit_d = '0;
                        c5_d     = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.credit      = credit_q;
    assign bus.qty         = qty_q;
    assign bus.state       = state_q;
    assign bus.led         = led_q;
    assign bus.coin_reject = rej_q;
    assign bus.change_5    = c5_q;
    assign bus.change_10   = c10_q;
    assign bus.vend_done   = done_q;
endmodule

// File: tb/tb_vend_ctrl_gen.sv
// Bench for vend_ctrl_gen: directed scenarios plus randomized purchase rounds
// scored against an arithmetic model of credit, quantity and change.
module tb_vend_ctrl_gen;
    localparam int TO = 40;
    localparam int FN = 4;
    localparam logic [6:0] M5  = 7'h01;
    localparam logic [6:0] M10 = 7'h02;
    localparam logic [6:0] CAN = 7'h04;
    localparam logic [6:0] CHK = 7'h08;
    localparam logic [6:0] DN  = 7'h10;
    localparam logic [6:0] UP  = 7'h20;
    localparam logic [6:0] TCK = 7'h40;

    logic clk = 1'b0;
    logic rst;
    int   cmp_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    vend_if #(.CW(6), .QW(4), .LED_W(16)) b ();
    vend_if #(.CW(6), .QW(2), .LED_W(16)) b2 ();

    vend_ctrl_gen #(.PRICE(5), .MAX_CREDIT(50), .MAX_QTY(9), .TIMEOUT_CYC(TO),
                    .FLASH_N(FN), .LED_W(16))
        dut (.clk(clk), .rst(rst), .bus(b));

    vend_ctrl_gen #(.PRICE(10), .MAX_CREDIT(50), .MAX_QTY(3), .TIMEOUT_CYC(TO),
                    .FLASH_N(FN), .LED_W(16))
        dut2 (.clk(clk), .rst(rst), .bus(b2));

    task automatic set_in(input logic [6:0] m);
        {b.tick, b.count_up, b.count_down, b.check, b.cancel, b.money_10, b.money_5} = m;
        {b2.tick, b2.count_up, b2.count_down, b2.check, b2.cancel, b2.money_10, b2.money_5} = m;
    endtask

    // apply one cycle of input pulses to both units; returns at the next falling edge
    task automatic drive(input logic [6:0] m);
        set_in(m);
        @(negedge clk);
        set_in(7'h00);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(7'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic payout(input bit sel, output int n10, output int n5);
        n10 = 0;
        n5  = 0;
        for (int i = 0; i < 30; i++) begin
            if ((sel ? b2.credit : b.credit) == 6'd0) break;
            drive(TCK);
            n10 += int'(sel ? b2.change_10 : b.change_10);
            n5  += int'(sel ? b2.change_5 : b.change_5);
        end
        @(negedge clk);
    endtask

    task automatic do_release(input bit sel, output int bad, output int dones);
        logic [15:0] led;
        bad   = 0;
        dones = 0;
        for (int i = 1; i <= 2 * FN; i++) begin
            drive(TCK);
            led = sel ? b2.led : b.led;
            dones += int'(sel ? b2.vend_done : b.vend_done);
            if (led !== ((i % 2 == 1) ? 16'hFFFF : 16'h0000)) bad++;
            if (i < 2 * FN && (sel ? b2.state : b.state) !== 3'd3) bad++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(7'h00);
        #12;
        cmp_cnt++;
        if ({b.state, b.credit, b.qty, b.led} !== 29'd0) begin
            err_cnt++;
            $display("FAIL reset_regs got st=%0d cr=%0d q=%0d led=%h want all 0", b.state, b.credit, b.qty, b.led);
        end
        cmp_cnt++;
        if ({b.coin_reject, b.change_5, b.change_10, b.vend_done} !== 4'b0) begin
            err_cnt++;
            $display("FAIL reset_pulses got %b want 0000", {b.coin_reject, b.change_5, b.change_10, b.vend_done});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cmp_cnt++;
        if (b.state !== 3'd1) begin
            err_cnt++;
            $display("FAIL reset_to_insert got state %0d want 1", b.state);
        end
    endtask

    task automatic test_basic_purchase();
        int bad, dones, n10, n5;
        do_reset();
        drive(M10); drive(M10); drive(M10); drive(M5);
        cmp_cnt++;
        if (b.credit !== 6'd35) begin err_cnt++; $display("FAIL basic_credit got %0d want 35", b.credit); end
        @(negedge clk);
        cmp_cnt++;
        if (b.qty !== 4'd7) begin err_cnt++; $display("FAIL basic_afford got %0d want 7", b.qty); end
        drive(CHK);
        drive(DN);
        drive(DN);
        cmp_cnt++;
        if (b.qty !== 4'd5 || b.state !== 3'd2) begin
            err_cnt++; $display("FAIL basic_select got q=%0d st=%0d want q=5 st=2", b.qty, b.state);
        end
        drive(CHK);
        cmp_cnt++;
        if (b.state !== 3'd3 || b.credit !== 6'd35) begin
            err_cnt++; $display("FAIL basic_release_entry got st=%0d cr=%0d want st=3 cr=35", b.state, b.credit);
        end
        do_release(1'b0, bad, dones);
        cmp_cnt++;
        if (bad !== 0 || dones !== 1) begin
            err_cnt++; $display("FAIL basic_flash got bad=%0d done=%0d want 0 and 1", bad, dones);
        end
        cmp_cnt++;
        if (b.state !== 3'd4 || b.credit !== 6'd10) begin
            err_cnt++; $display("FAIL basic_change_entry got st=%0d cr=%0d want st=4 cr=10", b.state, b.credit);
        end
        @(negedge clk);
        cmp_cnt++;
        if (b.vend_done !== 1'b0) begin err_cnt++; $display("FAIL basic_done_width got 1 want 0"); end
        payout(1'b0, n10, n5);
        cmp_cnt++;
        if (n10 !== 1 || n5 !== 0 || b.state !== 3'd0) begin
            err_cnt++; $display("FAIL basic_payout got c10=%0d c5=%0d st=%0d want 1 0 0", n10, n5, b.state);
        end
    endtask

    task automatic test_coin_limit();
        int n10, n5;
        do_reset();
        drive(M10); drive(M10); drive(M10); drive(M10); drive(M5);
        drive(M10);
        cmp_cnt++;
        if (b.coin_reject !== 1'b1 || b.credit !== 6'd45) begin
            err_cnt++; $display("FAIL limit_reject got rej=%0d cr=%0d want 1 45", b.coin_reject, b.credit);
        end
        @(negedge clk);
        cmp_cnt++;
        if (b.coin_reject !== 1'b0) begin err_cnt++; $display("FAIL limit_reject_width got 1 want 0"); end
        drive(M5);
        cmp_cnt++;
        if (b.credit !== 6'd50 || b.coin_reject !== 1'b0) begin
            err_cnt++; $display("FAIL limit_fill got cr=%0d rej=%0d want 50 0", b.credit, b.coin_reject);
        end
        drive(CAN);
        payout(1'b0, n10, n5);
        cmp_cnt++;
        if (n10 !== 5 || n5 !== 0 || b.state !== 3'd0) begin
            err_cnt++; $display("FAIL limit_refund got c10=%0d c5=%0d st=%0d want 5 0 0", n10, n5, b.state);
        end
        do_reset();
        drive(M10); drive(M10); drive(M10);
        drive(M10 | M5);
        cmp_cnt++;
        if (b.credit !== 6'd40 || b.coin_reject !== 1'b1) begin
            err_cnt++; $display("FAIL limit_both got cr=%0d rej=%0d want 40 1", b.credit, b.coin_reject);
        end
    endtask

    task automatic test_qty_wrap();
        int n10, n5;
        do_reset();
        drive(M10); drive(M10); drive(M10); drive(M5);
        drive(CHK);
        drive(UP);
        cmp_cnt++;
        if (b.qty !== 4'd1) begin err_cnt++; $display("FAIL wrap_up got %0d want 1", b.qty); end
        drive(DN);
        cmp_cnt++;
        if (b.qty !== 4'd7) begin err_cnt++; $display("FAIL wrap_down got %0d want 7", b.qty); end
        drive(UP | DN);
        cmp_cnt++;
        if (b.qty !== 4'd7) begin err_cnt++; $display("FAIL wrap_both got %0d want 7", b.qty); end
        drive(M5);
        cmp_cnt++;
        if (b.coin_reject !== 1'b1 || b.credit !== 6'd35) begin
            err_cnt++; $display("FAIL select_coin got rej=%0d cr=%0d want 1 35", b.coin_reject, b.credit);
        end
        drive(CAN | CHK);
        cmp_cnt++;
        if (b.state !== 3'd4) begin err_cnt++; $display("FAIL cancel_priority got state %0d want 4", b.state); end
        payout(1'b0, n10, n5);
        cmp_cnt++;
        if (n10 !== 3 || n5 !== 1) begin
            err_cnt++; $display("FAIL wrap_refund got c10=%0d c5=%0d want 3 1", n10, n5);
        end
    endtask

    task automatic test_timeout();
        int n, n10, n5;
        do_reset();
        drive(M10); drive(M10); drive(M5);
        drive(CHK);
        repeat (30) @(negedge clk);
        drive(DN);
        n = 0;
        while (b.state == 3'd2 && n < TO + 5) begin
            @(negedge clk);
            n++;
        end
        cmp_cnt++;
        if (n !== TO || b.state !== 3'd4 || b.credit !== 6'd25) begin
            err_cnt++; $display("FAIL timeout got cyc=%0d st=%0d cr=%0d want %0d 4 25", n, b.state, b.credit, TO);
        end
        drive(TCK);
        cmp_cnt++;
        if (b.change_10 !== 1'b1 || b.credit !== 6'd15) begin
            err_cnt++; $display("FAIL timeout_first got c10=%0d cr=%0d want 1 15", b.change_10, b.credit);
        end
        payout(1'b0, n10, n5);
        cmp_cnt++;
        if (n10 !== 1 || n5 !== 1 || b.state !== 3'd0) begin
            err_cnt++; $display("FAIL timeout_rest got c10=%0d c5=%0d st=%0d want 1 1 0", n10, n5, b.state);
        end
    endtask

    task automatic test_reset_release();
        do_reset();
        drive(M5);
        drive(CHK);
        drive(CHK);
        drive(TCK);
        cmp_cnt++;
        if (b.led !== 16'hFFFF || b.state !== 3'd3) begin
            err_cnt++; $display("FAIL mid_release got led=%h st=%0d want ffff 3", b.led, b.state);
        end
        #2 rst = 1'b1;
        #1;
        cmp_cnt++;
        if (b.led !== 16'h0 || b.state !== 3'd0 || b.credit !== 6'd0) begin
            err_cnt++; $display("FAIL async_reset got led=%h st=%0d cr=%0d want 0 0 0", b.led, b.state, b.credit);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cmp_cnt++;
        if (b.state !== 3'd1) begin err_cnt++; $display("FAIL async_reset_exit got %0d want 1", b.state); end
    endtask

    task automatic test_price10();
        int bad, dones, n10, n5;
        do_reset();
        drive(M10); drive(M10); drive(M10); drive(M10); drive(M5);
        @(negedge clk);
        cmp_cnt++;
        if (b2.credit !== 6'd45 || b2.qty !== 2'd3) begin
            err_cnt++; $display("FAIL p10_afford got cr=%0d q=%0d want 45 3", b2.credit, b2.qty);
        end
        drive(CHK);
        drive(CHK);
        do_release(1'b1, bad, dones);
        cmp_cnt++;
        if (bad !== 0 || dones !== 1 || b2.credit !== 6'd15) begin
            err_cnt++; $display("FAIL p10_release got bad=%0d done=%0d cr=%0d want 0 1 15", bad, dones, b2.credit);
        end
        payout(1'b1, n10, n5);
        cmp_cnt++;
        if (n10 !== 1 || n5 !== 1 || b2.state !== 3'd0) begin
            err_cnt++; $display("FAIL p10_payout got c10=%0d c5=%0d st=%0d want 1 1 0", n10, n5, b2.state);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            int cr, af, q, ch, k, op, n10, n5, bad, dones;
            logic [6:0] m;
            logic exp_rej;
            do_reset();
            cr = 0;
            k = $urandom_range(1, 14);
            for (int i = 0; i < k; i++) begin
                case ($urandom_range(0, 3))
                    0:       m = M5;
                    1:       m = M10;
                    2:       m = M5 | M10;
                    default: m = 7'h00;
                endcase
                exp_rej = 1'b0;
                if (m[1]) begin
                    if (cr + 10 <= 50) cr += 10; else exp_rej = 1'b1;
                end
                if (m[0]) begin
                    if (!m[1] && cr + 5 <= 50) cr += 5; else exp_rej = 1'b1;
                end
                drive(m);
                cmp_cnt++;
                if (int'(b.credit) != cr || b.coin_reject !== exp_rej) begin
                    err_cnt++;
                    $display("FAIL rnd_coin got cr=%0d rej=%0d want %0d %0d", b.credit, b.coin_reject, cr, exp_rej);
                end
            end
            if (cr == 0) begin drive(M5); cr = 5; end
            @(negedge clk);
            af = (cr / 5 > 9) ? 9 : cr / 5;
            cmp_cnt++;
            if (int'(b.qty) != af) begin err_cnt++; $display("FAIL rnd_afford got %0d want %0d", b.qty, af); end
            if ($urandom_range(0, 3) == 0) begin
                drive(CAN);
                ch = cr;
            end else begin
                drive(CHK);
                q = af;
                k = $urandom_range(0, 6);
                for (int i = 0; i < k; i++) begin
                    op = $urandom_range(0, 3);
                    case (op)
                        0:       begin drive(UP); q = q % af + 1; end
                        1:       begin drive(DN); q = (q + af - 2) % af + 1; end
                        2:       drive(UP | DN);
                        default: drive(M10);
                    endcase
                    cmp_cnt++;
                    if (int'(b.qty) != q || b.coin_reject !== (op == 3)) begin
                        err_cnt++; $display("FAIL rnd_select got q=%0d rej=%0d want %0d %0d", b.qty, b.coin_reject, q, op == 3);
                    end
                end
                drive(CHK);
                ch = cr - q * 5;
                do_release(1'b0, bad, dones);
                cmp_cnt++;
                if (bad != 0 || dones != 1 || int'(b.credit) != ch) begin
                    err_cnt++; $display("FAIL rnd_release got bad=%0d done=%0d cr=%0d want 0 1 %0d", bad, dones, b.credit, ch);
                end
            end
            payout(1'b0, n10, n5);
            cmp_cnt++;
            if (n10 != ch / 10 || n5 != (ch % 10) / 5 || b.state !== 3'd0) begin
                err_cnt++;
                $display("FAIL rnd_payout got c10=%0d c5=%0d st=%0d want %0d %0d 0", n10, n5, b.state, ch / 10, (ch % 10) / 5);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_purchase();
        test_coin_limit();
        test_qty_wrap();
        test_timeout();
        test_reset_release();
        test_price10();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/vend_ctrl_gen.md
VEND_CTRL_GEN -- requirements
Module: vend_ctrl_gen

Interface
REQ-001 SHALL have parameter PRICE, default 5, unit price in currency units (multiple of 5, >0).
REQ-002 SHALL have parameter MAX_CREDIT, default 50, credit ceiling (multiple of 5, >=10).
REQ-003 SHALL have parameter MAX_QTY, default 9, quantity ceiling (>=1).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 8192, idle clk cycles in SELECT before auto-refund.
REQ-005 SHALL have parameter FLASH_N, default 4, number of LED on/off flashes in RELEASE.
REQ-006 SHALL have parameter LED_W, default 16, LED bus width.
REQ-007 SHALL have ports: clk input 1, sole clock; rst input 1, asynchronous active-high reset.
REQ-008 SHALL have inputs money_5, money_10, cancel, check, count_down, count_up, each 1 bit, one-cycle pulses already debounced.
REQ-009 SHALL have input tick 1, one-cycle slow-rate strobe pacing RELEASE and CHANGE.
REQ-010 SHALL have outputs: credit CW=$clog2(MAX_CREDIT+1) bits; qty QW=$clog2(MAX_QTY+1) bits; state 3 bits; led LED_W bits.
REQ-011 SHALL have 1-bit pulse outputs coin_reject, change_5, change_10, vend_done.

Function
REQ-012 SHALL encode states IDLE=0, INSERT=1, SELECT=2, RELEASE=3, CHANGE=4; codes 5-7 go to IDLE next cycle.
REQ-013 IDLE SHALL clear credit, qty, change register, led and move to INSERT next cycle.
REQ-014 INSERT: money_10 SHALL add 10 if credit+10<=MAX_CREDIT, else credit unchanged and coin_reject pulses 1 cycle.
REQ-015 INSERT: money_5 SHALL add 5 if credit+5<=MAX_CREDIT, else coin_reject; money_5 with money_10 same cycle: money_10 processed, money_5 rejected.
REQ-016 INSERT: qty SHALL track afford = min(credit/PRICE, MAX_QTY), updated the cycle after each accepted coin.
REQ-017 INSERT: cancel with credit>0 SHALL go to CHANGE; check with credit>0 and afford>=1 SHALL go to SELECT; cancel beats check; both ignored at credit 0.
REQ-018 A coin coincident with cancel/check SHALL be added before the transition (credit includes it).
REQ-019 SELECT: qty starts at afford; count_down decrements, 1 wraps to afford; count_up increments, afford wraps to 1; both same cycle: no change.
REQ-020 SELECT priority SHALL be cancel > check > count_up/count_down; coins in SELECT are rejected with coin_reject.
REQ-021 SELECT check SHALL latch change = credit - qty*PRICE and go to RELEASE.
REQ-022 SELECT idle counter SHALL reset on entry and on any button pulse; reaching TIMEOUT_CYC SHALL go to CHANGE with full credit.
REQ-023 RELEASE: each tick SHALL toggle led between all-ones and zero; after FLASH_N all-ones phases and the following zero, credit <= change, vend_done pulses, go to CHANGE.
REQ-024 CHANGE: each tick SHALL pay credit>=10 by subtracting 10 with change_10 pulse, else credit==5 by subtracting 5 with change_5 pulse; credit 0 -> IDLE.
REQ-025 Arithmetic SHALL never wrap: credit within 0..MAX_CREDIT, qty within 0..MAX_QTY; qty*PRICE computed at CW+QW bits.
REQ-026 All pulse outputs SHALL be registered, high exactly one cycle, low otherwise.

Reset
REQ-027 rst SHALL immediately force state IDLE, credit 0, qty 0, led 0, change 0, all pulses 0, counters 0, including mid-RELEASE or mid-CHANGE.
REQ-028 After rst deasserts, IDLE->INSERT SHALL occur on the first clk edge.

Verification
REQ-029 money_10 x3, money_5, check, count_down x2, check -> credit 35, afford 7, qty 5, change 10, 4 flashes, one change_10, IDLE.
REQ-030 credit 45, money_10 -> coin_reject 1 cycle, credit stays 45; money_5 -> credit 50.
REQ-031 SELECT qty=1, count_down -> qty=afford; qty=afford, count_up -> qty=1; both together -> unchanged.
REQ-032 SELECT no input TIMEOUT_CYC cycles with credit 25 -> CHANGE, change_10,change_10,change_5 on successive ticks, IDLE.
REQ-033 rst asserted during RELEASE led all-ones -> led 0, state 0, credit 0 without clk edge.
REQ-034 PRICE=10, MAX_QTY=3, credit 45 -> afford 3; check,check -> change 15 paid as change_10, change_5.
